sra_req_64b: RTL and testbench

- Request front-end placed directly upstream of the 64-bit one-hot shifter (sra_64b).
- Accepts shift requests with a binary amount over a valid/ready handshake and registers the operands.
- Decodes the amount to the shifter's one-hot shift vector, pulses the shifter's init, captures its result on done, and presents it on a valid/ready output.
- Handles amounts ≥64 locally, without issuing to the shifter.

---
 rtl/sra_req_64b.sv | 172 +++++++++++++++++
 tb/tb_sra_req_64b.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sra_req_64b.sv
// sra_req_64b: valid/ready request front-end for the sra_64b one-hot shifter.
// Optional operation counter (op_cnt_o, stat_clr_i) is built when SRA_REQ_STAT_EN is defined.
module sra_req_64b #(
  parameter logic SH_OUT_REG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_arith_i,
  input  logic [6:0]  in_amt_i,
  input  logic [63:0] in_data_i,
  output logic        sh_init_o,
  output logic        sh_arith_o,
  output logic [63:0] sh_shift_o,
  output logic [63:0] sh_data_o,
  input  logic        sh_done_i,
  input  logic [63:0] sh_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
`ifdef SRA_REQ_STAT_EN
  input  logic        stat_clr_i,
  output logic [31:0] op_cnt_o,
`endif
  output logic [63:0] out_data_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FULL  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        sh_init_q, sh_init_d;
  logic        sh_arith_q, sh_arith_d;
  logic [63:0] sh_shift_q, sh_shift_d;
  logic [63:0] sh_data_q, sh_data_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic        early_done_s;

  // Amount 0 means pass-through, which the shifter encodes as an all-zero vector.
  function automatic logic [63:0] amt_to_onehot(input logic [5:0] amt);
    return (amt == 6'd0) ? 64'd0 : (64'd1 << amt);
  endfunction

  // A done in the init cycle is only meaningful for a combinational shifter output.
  assign early_done_s = sh_done_i & ~SH_OUT_REG;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    sh_init_d   = 1'b0;
    sh_arith_d  = sh_arith_q;
    sh_shift_d  = sh_shift_q;
    sh_data_d   = sh_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          in_ready_d = 1'b0;
          if (in_amt_i[6]) begin
            state_d     = FULL;
            out_valid_d = 1'b1;
            out_data_d  = {64{in_arith_i & in_data_i[63]}};
          end else begin
            state_d    = ISSUE;
            sh_init_d  = 1'b1;
            sh_arith_d = in_arith_i;
            sh_shift_d = amt_to_onehot(in_amt_i[5:0]);
            sh_data_d  = in_data_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, WAIT: begin
        if ((state_q == ISSUE) ? early_done_s : sh_done_i) begin
          state_d     = FULL;
          out_valid_d = 1'b1;
          out_data_d  = sh_data_i;
          sh_arith_d  = 1'b0;
          sh_shift_d  = 64'd0;
          sh_data_d   = 64'd0;
        end else begin
          state_d = WAIT;
        end
      end
      FULL: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        sh_arith_d  = 1'b0;
        sh_shift_d  = 64'd0;
        sh_data_d   = 64'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      sh_init_q   <= 1'b0;
      sh_arith_q  <= 1'b0;
      sh_shift_q  <= 64'd0;
      sh_data_q   <= 64'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      sh_init_q   <= sh_init_d;
      sh_arith_q  <= sh_arith_d;
      sh_shift_q  <= sh_shift_d;
      sh_data_q   <= sh_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign sh_init_o   = sh_init_q;
  assign sh_arith_o  = sh_arith_q;
  assign sh_shift_o  = sh_shift_q;
  assign sh_data_o   = sh_data_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

`ifdef SRA_REQ_STAT_EN
  logic [31:0] op_cnt_q, op_cnt_d;

  // Saturating transfer counter; clear takes priority over a same-cycle transfer.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (stat_clr_i) begin
      op_cnt_d = 32'd0;
    end else if (out_valid_q && out_ready_i && (op_cnt_q != 32'hFFFF_FFFF)) begin
      op_cnt_d = op_cnt_q + 32'd1;
    end else begin
      op_cnt_d = op_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_cnt_q <= 32'd0;
    end else begin
      op_cnt_q <= op_cnt_d;
    end
  end

  assign op_cnt_o = op_cnt_q;
`endif

endmodule

// File: tb/tb_sra_req_64b.sv
// Bench for sra_req_64b: unit 0 faces a registered shifter (SH_OUT_REG=1), unit 1 a
// combinational one (SH_OUT_REG=0); results are predicted from the shift rules directly.
module tb_sra_req_64b;

  logic clk;
  logic rst_n;
  logic [1:0]       in_valid, in_ready, in_arith;
  logic [1:0][6:0]  in_amt;
  logic [1:0][63:0] in_data;
  logic [1:0]       sh_init, sh_arith, sh_done;
  logic [1:0][63:0] sh_shift, sh_dout, sh_res;
  logic [1:0]       out_valid, out_ready;
  logic [1:0][63:0] out_data;
  logic [1:0]       stale_done;
  logic             hold_done;
`ifdef SRA_REQ_STAT_EN
  logic [1:0]       stat_clr;
  logic [1:0][31:0] op_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int exp_cnt[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sra_req_64b #(.SH_OUT_REG(1'b1)) u_dut_reg (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_arith_i(in_arith[0]),
    .in_amt_i(in_amt[0]), .in_data_i(in_data[0]),
    .sh_init_o(sh_init[0]), .sh_arith_o(sh_arith[0]), .sh_shift_o(sh_shift[0]),
    .sh_data_o(sh_dout[0]), .sh_done_i(sh_done[0]), .sh_data_i(sh_res[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
`ifdef SRA_REQ_STAT_EN
    .stat_clr_i(stat_clr[0]), .op_cnt_o(op_cnt[0]),
`endif
    .out_data_o(out_data[0])
  );

  sra_req_64b #(.SH_OUT_REG(1'b0)) u_dut_comb (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_arith_i(in_arith[1]),
    .in_amt_i(in_amt[1]), .in_data_i(in_data[1]),
    .sh_init_o(sh_init[1]), .sh_arith_o(sh_arith[1]), .sh_shift_o(sh_shift[1]),
    .sh_data_o(sh_dout[1]), .sh_done_i(sh_done[1]), .sh_data_i(sh_res[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
`ifdef SRA_REQ_STAT_EN
    .stat_clr_i(stat_clr[1]), .op_cnt_o(op_cnt[1]),
`endif
    .out_data_o(out_data[1])
  );

  // Behavioural shifter: shift by the index of the set bit (none set = no shift).
  function automatic logic [63:0] shifter_model(input logic ar, input logic [63:0] oh,
                                                input logic [63:0] d);
    int k;
    k = 0;
    for (int i = 0; i < 64; i++) if (oh[i]) k = i;
    return ar ? 64'($signed(d) >>> k) : (d >> k);
  endfunction

  // Expected result of a request, straight from the shift rules.
  function automatic logic [63:0] ref_sra(input logic ar, input int amt, input logic [63:0] d);
    if (amt >= 64) return (ar && d[63]) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
    return ar ? 64'($signed(d) >>> amt) : (d >> amt);
  endfunction

  logic        done_q0;
  logic [63:0] res_q0;
  always @(posedge clk) begin
    done_q0 <= sh_init[0] & ~hold_done;
    res_q0  <= shifter_model(sh_arith[0], sh_shift[0], sh_dout[0]);
  end
  assign sh_done[0] = done_q0 | stale_done[0];
  assign sh_res[0]  = res_q0;
  assign sh_done[1] = sh_init[1] | stale_done[1];
  assign sh_res[1]  = shifter_model(sh_arith[1], sh_shift[1], sh_dout[1]);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full request/response on unit u; called #1 after a rising edge with the unit idle.
  task automatic xfer(input int u, input logic ar, input int amt, input logic [63:0] d,
                      input int hold, input bit clr);
    logic [63:0] exp;
    logic [63:0] exp_oh;
    int lat;
    int exp_lat;
    exp     = ref_sra(ar, amt, d);
    exp_oh  = (amt == 0) ? 64'd0 : (64'd1 << amt);
    exp_lat = (amt >= 64) ? 1 : ((u == 0) ? 3 : 2);
    check_val("idle_ready", {63'd0, in_ready[u]}, 64'd1);
    in_valid[u] = 1'b1;
    in_arith[u] = ar;
    in_amt[u]   = 7'(amt);
    in_data[u]  = d;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    lat = 1;
    check_val("busy_ready", {63'd0, in_ready[u]}, 64'd0);
    if (amt < 64) begin
      check_val("init_pulse", {63'd0, sh_init[u]}, 64'd1);
      check_val("shift_vec", sh_shift[u], exp_oh);
      check_val("sh_data", sh_dout[u], d);
      check_val("sh_arith", {63'd0, sh_arith[u]}, {63'd0, ar});
    end else begin
      check_val("bypass_no_init", {63'd0, sh_init[u]}, 64'd0);
    end
    while (out_valid[u] !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      check_val("init_once", {63'd0, sh_init[u]}, 64'd0);
    end
    check_val("latency", 64'(lat), 64'(exp_lat));
    check_val("out_valid", {63'd0, out_valid[u]}, 64'd1);
    check_val("out_data", out_data[u], exp);
    check_val("full_shift_zero", sh_shift[u], 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid[u] = 1'b1;
      in_amt[u]   = 7'($urandom_range(0, 127));
      in_data[u]  = {$urandom, $urandom};
      @(posedge clk); #1;
      check_val("bp_valid", {63'd0, out_valid[u]}, 64'd1);
      check_val("bp_data", out_data[u], exp);
      check_val("bp_ready", {63'd0, in_ready[u]}, 64'd0);
    end
    out_ready[u] = 1'b1;
`ifdef SRA_REQ_STAT_EN
    stat_clr[u] = clr;
`endif
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    in_valid[u]  = 1'b0;
`ifdef SRA_REQ_STAT_EN
    stat_clr[u] = 1'b0;
`endif
    exp_cnt[u] = clr ? 0 : exp_cnt[u] + 1;
    check_val("post_valid", {63'd0, out_valid[u]}, 64'd0);
    check_val("post_ready", {63'd0, in_ready[u]}, 64'd1);
    check_val("post_data_kept", out_data[u], exp);
`ifdef SRA_REQ_STAT_EN
    check_val("op_cnt", {32'd0, op_cnt[u]}, 64'(exp_cnt[u]));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0; in_arith = '0; in_amt = '0; in_data = '0;
    out_ready = '0; stale_done = '0; hold_done = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
`ifdef SRA_REQ_STAT_EN
    stat_clr = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check_val("rst_in_ready", {63'd0, in_ready[u]}, 64'd1);
      check_val("rst_out_valid", {63'd0, out_valid[u]}, 64'd0);
      check_val("rst_sh_init", {63'd0, sh_init[u]}, 64'd0);
      check_val("rst_sh_shift", sh_shift[u], 64'd0);
      check_val("rst_out_data", out_data[u], 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1'b1, 4, 64'h8000_0000_0000_0010, 0, 1'b0);
    xfer(1, 1'b0, 0, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
    xfer(0, 1'b1, 64, 64'h8000_0000_0000_0001, 0, 1'b0);
    xfer(0, 1'b1, 127, 64'hC000_0000_0000_0000, 0, 1'b0);
    xfer(1, 1'b0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    xfer(1, 1'b1, 127, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1'b0);
    xfer(0, 1'b1, 63, 64'h8000_0000_0000_0000, 0, 1'b0);
    xfer(1, 1'b1, 1, 64'h8000_0000_0000_0003, 0, 1'b0);
    xfer(0, 1'b0, 17, 64'h0123_4567_89AB_CDEF, 10, 1'b0);
    xfer(1, 1'b1, 70, 64'h8000_0000_0000_0000, 10, 1'b0);

    // Reset while the registered-shifter unit waits for a done that never comes.
    hold_done   = 1'b1;
    in_valid[0] = 1'b1; in_arith[0] = 1'b0; in_amt[0] = 7'd5; in_data[0] = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("wait_ready", {63'd0, in_ready[0]}, 64'd0);
    check_val("wait_valid", {63'd0, out_valid[0]}, 64'd0);
    rst_n = 1'b0;
    #2;
    check_val("arst_ready", {63'd0, in_ready[0]}, 64'd1);
    check_val("arst_init", {63'd0, sh_init[0]}, 64'd0);
    #2;
    rst_n = 1'b1;
    hold_done = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    @(posedge clk); #1;
    check_val("rel_ready", {63'd0, in_ready[0]}, 64'd1);
    check_val("rel_valid", {63'd0, out_valid[0]}, 64'd0);
    stale_done[0] = 1'b1;
    @(posedge clk); #1;
    stale_done[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("stale_valid", {63'd0, out_valid[0]}, 64'd0);
      check_val("stale_ready", {63'd0, in_ready[0]}, 64'd1);
      @(posedge clk); #1;
    end

`ifdef SRA_REQ_STAT_EN
    for (int i = 0; i < 5; i++)
      xfer(0, 1'($urandom), (i == 2) ? 100 : int'($urandom_range(0, 63)), {$urandom, $urandom}, 0, 1'b0);
    check_val("cnt_five", {32'd0, op_cnt[0]}, 64'd5);
    xfer(0, 1'b1, 9, {$urandom, $urandom}, 1, 1'b1);
    check_val("cnt_clr_wins", {32'd0, op_cnt[0]}, 64'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      int u;
      int amt;
      u   = int'($urandom_range(0, 1));
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 127)) : int'($urandom_range(0, 63));
      xfer(u, 1'($urandom), amt, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
